// File: rtl/spi_pwm_config_rx_pkg.sv
// Shared constants, frame layout and receiver FSM states for the SPI PWM configuration front end.
package spi_pwm_pkg;

  localparam int              CHAN_IDX_W    = 3;
  localparam logic [2:0]      BROADCAST_IDX = 3'd7;
  localparam int              FRAME_BITS    = 8;
  localparam int              DUTY_BITS     = 3;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD
  } rx_state_e;

  typedef struct packed {
    logic [CHAN_IDX_W-1:0] idx;
    logic [1:0]            rsvd;
    logic [DUTY_BITS-1:0]  duty;
  } frame_t;

endpackage

// File: rtl/spi_pwm_config_rx_if.sv
// SPI pins plus the duty/update/frame_err outputs toward the PWM driver.
interface spi_pwm_config_rx_if #(
  parameter int CHANNELS = 7
);
  import spi_pwm_pkg::*;

  logic                          sclk;
  logic                          cs_n;
  logic                          mosi;
  logic [CHANNELS*DUTY_BITS-1:0] duty;
  logic                          update;
  logic                          frame_err;

  modport master (
    output sclk, cs_n, mosi,
    input  duty, update, frame_err
  );

  modport slave (
    input  sclk, cs_n, mosi,
    output duty, update, frame_err
  );

endinterface

// File: rtl/spi_pwm_config_rx_sync.sv
// Purpose: 2-flop synchronizer with registered rise/fall detect for one async pin.
// Latency: level and edge pulses appear 3 clk edges after the pin changes.
// Backpressure: none; free-running sampler.
module spi_in_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= RST_VAL;
      s2   <= RST_VAL;
      s3   <= RST_VAL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= d;
      s2   <= s1;
      s3   <= s2;
      rise <= s2 & ~s3;
      fall <= ~s2 & s3;
    end
  end

  // s3 is the level aligned with the edge pulses, so level and edge decisions agree in time
  assign q = s3;

endmodule

// File: rtl/spi_pwm_config_rx.sv
// Purpose: SPI mode-0 slave that decodes 8-bit {idx, rsvd, duty} frames into per-channel duty registers.
// Latency: duty/update registered one clk after the 8th synchronized sclk rise (pin edge + 4 clk).
// Backpressure: none; frames beyond 8 bits are ignored until cs_n deasserts.
module spi_pwm_config_rx #(
  parameter int CHANNELS  = 7,
  parameter int DUTY_BITS = spi_pwm_pkg::DUTY_BITS
) (
  input  logic               clk,
  input  logic               rst,
  spi_pwm_config_rx_if.slave bus
);
  import spi_pwm_pkg::*;

  logic sclk_rise, cs_lvl, cs_fall;
  logic unused_sclk_lvl, unused_sclk_fall, unused_cs_rise;
  logic mosi_s1, mosi_s2;

  spi_in_sync #(.RST_VAL(1'b0)) u_sclk_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (bus.sclk),
    .q    (unused_sclk_lvl),
    .rise (sclk_rise),
    .fall (unused_sclk_fall)
  );

  // cs_n resets high so the FSM does not see a phantom frame start out of reset
  spi_in_sync #(.RST_VAL(1'b1)) u_cs_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (bus.cs_n),
    .q    (cs_lvl),
    .rise (unused_cs_rise),
    .fall (cs_fall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      mosi_s1 <= bus.mosi;
      mosi_s2 <= mosi_s1;
    end
  end

  rx_state_e                     state_q, state_d;
  logic [2:0]                    cnt_q;
  logic [FRAME_BITS-1:0]         shift_q, shift_d;
  frame_t                        frame;
  logic [CHANNELS*DUTY_BITS-1:0] duty_q;
  logic                          update_q, err_q;
  logic                          do_shift, do_apply, do_abort;
  logic                          idx_ok, idx_bcast, idx_good;
  logic [2:0]                    unused_bits;

  assign shift_d     = {shift_q[FRAME_BITS-2:0], mosi_s2};
  assign frame       = frame_t'(shift_d);
  assign unused_bits = {shift_q[FRAME_BITS-1], frame.rsvd};
  assign idx_bcast   = (frame.idx == BROADCAST_IDX);
  assign idx_ok      = (int'(frame.idx) < CHANNELS);
  assign idx_good    = idx_ok | idx_bcast;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    do_shift = 1'b0;
    do_apply = 1'b0;
    do_abort = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall || !cs_lvl) state_d = SHIFT;
      end
      SHIFT: begin
        // completing the 8th bit wins over a simultaneous cs_n release
        if (sclk_rise && cnt_q == 3'(FRAME_BITS - 1)) begin
          do_shift = 1'b1;
          do_apply = 1'b1;
          state_d  = HOLD;
        end else if (cs_lvl) begin
          do_abort = 1'b1;
          state_d  = IDLE;
        end else if (sclk_rise) begin
          do_shift = 1'b1;
        end
      end
      HOLD: begin
        if (cs_lvl) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      shift_q  <= '0;
      duty_q   <= '0;
      update_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      update_q <= do_apply & idx_good;
      err_q    <= do_abort | (do_apply & ~idx_good);
      if (state_q == IDLE || do_abort) cnt_q <= '0;
      else if (do_shift)               cnt_q <= cnt_q + 3'd1;
      if (do_shift) shift_q <= shift_d;
      if (do_apply) begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (idx_bcast || int'(frame.idx) == i)
            duty_q[i*DUTY_BITS +: DUTY_BITS] <= DUTY_BITS'(frame.duty);
        end
      end
    end
  end

  assign bus.duty      = duty_q;
  assign bus.update    = update_q;
  assign bus.frame_err = err_q;

endmodule

// File: doc/spi_pwm_config_rx.md
# spi_pwm_config_rx

SPI-slave configuration front end for the 3-bit multi-channel PWM driver. It receives 8-bit frames from an external SPI master, decodes a channel index and a duty value, and holds one duty register per channel. The packed duty bus and an update strobe feed the PWM driver directly downstream. All logic runs on the single system clock, which is the same clock used by the PWM driver.

## Interface
Parameters:
- CHANNELS, 7: number of duty registers; legal range 1..7.
- DUTY_BITS, 3: width of each duty value; fixed at 3 by the frame format.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous and active-high.
- sclk  in  1  SPI clock from master; asynchronous to clk.
- cs_n  in  1  SPI chip select, active-low; asynchronous to clk.
- mosi  in  1  SPI data in; asynchronous to clk.
- duty  out  CHANNELS*DUTY_BITS  packed duty registers; channel n occupies bits [3n+2:3n].
- update  out  1  one-cycle pulse, high in the first cycle that new duty values are visible.
- frame_err  out  1  one-cycle pulse on an aborted frame or an out-of-range index.

## Operation
- SPI mode 0: mosi sampled on rising sclk, MSB first, exactly 8 bits per frame.
- Frame format:
  - [7:5] channel index.
  - [4:3] reserved; ignored.
  - [2:0] duty.
- sclk, cs_n and mosi each pass through a 2-flop synchronizer. Rising-sclk and falling-cs_n edges are detected on the synchronized signals.
- FSM states IDLE, SHIFT, HOLD:
  - IDLE: bit counter is cleared. Synchronized cs_n low -> SHIFT.
  - SHIFT: each detected rising sclk shifts the synchronized mosi into an 8-bit shift register, and the bit counter increments.
    - After the 8th bit: apply the frame, then -> HOLD.
    - Synchronized cs_n high before 8 bits: discard the frame, pulse frame_err, -> IDLE.
  - HOLD: ignore further sclk edges. Synchronized cs_n high -> IDLE.
- Apply rules:
  - Index < CHANNELS: write that channel's register only.
  - Index == 7: broadcast the duty to all channels.
  - Index in [CHANNELS, 6]: no write, pulse frame_err, no update pulse.
- update pulses only on a successful write. It pulses even when the written value equals the old value.
- rst at any point (including mid-frame): registers clear immediately and the FSM returns to IDLE. A frame in flight is lost; the master must reassert cs_n to start a new one.

## Timing
- Reset values: duty = 0, update = 0, frame_err = 0, FSM in IDLE, counter = 0.
- Input latency: 2 synchronizer cycles plus 1 edge-detect cycle. A pin edge is acted on in the 3rd clk cycle after it.
- Master constraints:
  - sclk high and low phases are each at least 3 clk periods.
  - mosi is stable from 1 clk before to 3 clk after each rising sclk.
  - cs_n setup to the first sclk rising edge is at least 3 clk periods.
- Write timing: duty and update are registered on the same clk edge, the one following detection of the 8th sclk rising edge. update is high for exactly that one cycle.
- frame_err timing: high for one cycle, registered one edge after the abort or the bad index is detected.
- Back-to-back frames are allowed once cs_n returns high and is seen high for at least 1 synchronized cycle.
- A cs_n rise coinciding with the 8th sclk edge detection: the frame is completed and applied, not aborted.

## Structure
- Shared package spi_pwm_pkg:
  - CHAN_IDX_W = 3.
  - BROADCAST_IDX = 3'd7.
  - FRAME_BITS = 8.
  - DUTY_BITS = 3.
  - FSM state enum {IDLE, SHIFT, HOLD}.
- One sub-module, spi_in_sync: 2-flop synchronizer with registered edge detect. Instantiated for sclk and cs_n; mosi uses the synchronizer path only.
- Top-level module: FSM, shift register, 3-bit bit counter, duty register array.

## Test plan
- Reset: rst high mid-operation -> duty = 0, update = 0 and frame_err = 0 in the same cycle; a following frame 0x25 (channel 1, duty 5) -> duty[5:3] = 5 and one update pulse.
- Single write: frame 0xC3 (channel 6, duty 3) -> duty[20:18] = 3, all other channels unchanged, update pulse exactly 1 cycle wide.
- Broadcast: frame 0xE7 -> all 7 channels = 7 with one update pulse; then frame 0x02 -> channel 0 = 2, others stay 7.
- Abort: cs_n raised after 5 bits of 0x44 -> frame_err pulse, duty unchanged, no update; the next full frame 0x44 (channel 2, duty 4) -> channel 2 = 4.
- Overlong frame: 12 sclk cycles while cs_n is low, first 8 bits = 0x61 (channel 3, duty 1) -> channel 3 = 1, a single update pulse, extra bits ignored.
- Bad index with CHANNELS=4: frame 0xA6 (index 5) -> frame_err pulse, no write, no update pulse.
